// File: rtl/div_unit.sv
// div_unit: 32-bit radix-2 restoring divider, fixed 33-cycle latency, signed/unsigned quotient/remainder
module div_unit (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic [1:0]  FUNCT,
  input  logic        START,
  output logic [31:0] RESULT,
  output logic        BUSY,
  output logic        DONE
);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE_S} state_t;
  state_t st, nx;
  logic [31:0] quo, rem, dvs, orig, q_f, r_f, res_n;
  logic [32:0] sh, diff;
  logic [5:0] cnt;
  logic [1:0] fn;
  logic na, nb, sgn_in;
  assign sgn_in = ~FUNCT[0];
  assign BUSY = (st == ITER) || (st == FIX);
  assign DONE = st == DONE_S;
  // bit 32 of the 33-bit trial is set exactly when the shifted remainder is below the divisor
  always_comb begin
    nx = (st == IDLE) ? (START ? ITER : IDLE) :
         (st == ITER) ? ((cnt == 6'd31) ? FIX : ITER) :
         (st == FIX)  ? DONE_S : IDLE;
    sh = {rem, quo[31]};
    diff = sh - {1'b0, dvs};
    q_f = (~fn[0] & (na ^ nb)) ? -quo : quo;
    r_f = (~fn[0] & na) ? -rem : rem;
    res_n = (dvs == 32'd0) ? (fn[1] ? orig : 32'hFFFFFFFF) : (fn[1] ? r_f : q_f);
  end
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      st <= IDLE;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      orig <= '0;
      cnt <= '0;
      fn <= '0;
      na <= 1'b0;
      nb <= 1'b0;
      RESULT <= '0;
    end else begin
      st <= nx;
      if (st == IDLE && START) begin
        fn <= FUNCT;
        orig <= DATA1;
        na <= DATA1[31];
        nb <= DATA2[31];
        quo <= (sgn_in & DATA1[31]) ? -DATA1 : DATA1;
        dvs <= (sgn_in & DATA2[31]) ? -DATA2 : DATA2;
        rem <= '0;
        cnt <= '0;
      end else if (st == ITER) begin
        cnt <= cnt + 6'd1;
        rem <= diff[32] ? sh[31:0] : diff[31:0];
        quo <= {quo[30:0], ~diff[32]};
      end
      if (st == FIX) RESULT <= res_n;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven directed vectors plus hand-written timing, abort and ignore-start sequences
module tb_div_unit;
  logic CLK, RESETN, START, BUSY, DONE;
  logic [31:0] DATA1, DATA2, RESULT;
  logic [1:0] FUNCT;
  int vecs = 0, errs = 0;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
  typedef struct {
    logic [1:0]  fn;
    logic [31:0] a, b, exp;
  } vec_t;
  vec_t v[20];

  div_unit dut (.CLK(CLK), .RESETN(RESETN), .DATA1(DATA1), .DATA2(DATA2), .FUNCT(FUNCT),
                .START(START), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE));

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b);
    FUNCT = fn; DATA1 = a; DATA2 = b; START = 1;
    @(negedge CLK);
    START = 0;
  endtask

  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (!DONE && n < 50) begin
      if (BUSY) bc++;
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic op(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp, input string nm);
    int n, bc;
    @(negedge CLK);
    chk({nm, " done_one_cycle"}, {31'd0, DONE}, 32'd0);
    launch(fn, a, b);
    wait_done(n, bc);
    chk({nm, " result"}, RESULT, exp);
    chk({nm, " latency"}, n, 33);
    chk({nm, " busy_cycles"}, bc, 33);
  endtask

  initial begin
    int n, pulses, first;
    v[0]  = '{DIV,  32'h00000014, 32'hFFFFFFFD, 32'hFFFFFFFA};
    v[1]  = '{REM,  32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFE};
    v[2]  = '{REMU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    v[3]  = '{DIVU, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF};
    v[4]  = '{DIV,  32'h00000007, 32'h00000000, 32'hFFFFFFFF};
    v[5]  = '{DIVU, 32'h00000007, 32'h00000000, 32'hFFFFFFFF};
    v[6]  = '{REM,  32'h00000007, 32'h00000000, 32'h00000007};
    v[7]  = '{REM,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9};
    v[8]  = '{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    v[9]  = '{REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    v[10] = '{DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    v[11] = '{DIV,  32'hFFFFFFEC, 32'hFFFFFFFD, 32'h00000006};
    v[12] = '{REM,  32'h00000014, 32'hFFFFFFFD, 32'h00000002};
    v[13] = '{REMU, 32'h00000064, 32'h00000007, 32'h00000002};
    v[14] = '{DIVU, 32'h00000064, 32'h00000007, 32'h0000000E};
    v[15] = '{DIV,  32'h80000000, 32'h00000001, 32'h80000000};
    v[16] = '{REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    v[17] = '{DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    v[18] = '{REMU, 32'h00000007, 32'h00000000, 32'h00000007};
    v[19] = '{DIV,  32'h00000000, 32'h00000005, 32'h00000000};
    RESETN = 0; START = 0; DATA1 = 0; DATA2 = 0; FUNCT = 0;
    repeat (2) @(negedge CLK);
    chk("reset result", RESULT, 32'd0);
    chk("reset busy", {31'd0, BUSY}, 32'd0);
    chk("reset done", {31'd0, DONE}, 32'd0);
    RESETN = 1;
    for (int i = 0; i < 20; i++) op(v[i].fn, v[i].a, v[i].b, v[i].exp, $sformatf("vec%0d", i));
    // operands change at cycle 2 and START is re-pulsed at cycle 5; both must be ignored
    @(negedge CLK);
    launch(DIV, 32'h00000014, 32'hFFFFFFFD);
    n = 0; pulses = 0; first = -1;
    while (n < 60) begin
      if (n == 2) begin DATA1 = 32'd1000; DATA2 = 32'd7; FUNCT = REMU; end
      START = (n == 5);
      if (DONE) begin
        pulses++;
        if (first < 0) first = n;
      end
      @(negedge CLK);
      n++;
    end
    START = 0;
    chk("ignore_start pulses", pulses, 1);
    chk("ignore_start latency", first, 33);
    chk("ignore_start result", RESULT, 32'hFFFFFFFA);
    // back-to-back issues
    op(DIVU, 32'd1000, 32'd7, 32'd142, "b2b_first");
    op(REMU, 32'd1000, 32'd7, 32'd6, "b2b_second");
    // reset at cycle 10 aborts; START during reset is ignored
    @(negedge CLK);
    launch(DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge CLK);
    RESETN = 0; START = 1;
    @(negedge CLK);
    RESETN = 1; START = 0;
    chk("abort busy", {31'd0, BUSY}, 32'd0);
    chk("abort result", RESULT, 32'd0);
    pulses = 0;
    first = 0;
    repeat (40) begin
      if (DONE) pulses++;
      if (BUSY) first++;
      @(negedge CLK);
    end
    chk("abort no_done", pulses, 0);
    chk("abort stays_idle", first, 0);
    op(DIV, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, "after_abort");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RESETN, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port DATA1, input, 32 bits: the dividend.
REQ-004 SHALL have port DATA2, input, 32 bits: the divisor.
REQ-005 SHALL have port FUNCT, input, 2 bits: 00 DIV (signed quotient), 01 DIVU (unsigned quotient), 10 REM (signed remainder), 11 REMU (unsigned remainder).
REQ-006 SHALL have port START, input, 1 bit: request a new operation.
REQ-007 SHALL have port RESULT, output, 32 bits: registered quotient or remainder.
REQ-008 SHALL have port BUSY, output, 1 bit: high while an operation is in flight.
REQ-009 SHALL have port DONE, output, 1 bit: one-cycle pulse when RESULT is updated.

Function
REQ-010 SHALL implement the states IDLE, ITER, FIX and DONE_S.
REQ-011 In IDLE, when START=1 at rising edge k, SHALL capture DATA1, DATA2 and FUNCT; store the dividend and divisor as magnitudes (two's complement negate when the op is signed and bit 31=1); clear the remainder accumulator and iteration counter; and go to ITER.
REQ-012 SHALL drive BUSY=1 from edge k through the edge that enters DONE_S, and BUSY=0 in IDLE and DONE_S.
REQ-013 Each ITER cycle SHALL do one radix-2 restoring step: shift {rem, quo} left by 1; if the 33-bit trial (rem - divisor) is non-negative, keep the difference and set the quotient LSB to 1.
REQ-014 SHALL do exactly 32 ITER cycles (edges k+1..k+32) using a 6-bit counter, then go to FIX.
REQ-015 In FIX (edge k+33), SHALL select the quotient for DIV/DIVU and the remainder for REM/REMU, and register it into RESULT.
REQ-016 SHALL negate the quotient when the op is signed and the operand signs differ.
REQ-017 SHALL negate the remainder when the op is signed and the dividend is negative.
REQ-018 SHALL then go to DONE_S.
REQ-019 SHALL assert DONE=1 for exactly the one cycle after edge k+33, then return to IDLE at edge k+34; start-to-DONE latency is 33 cycles.
REQ-020 Divide by zero (captured divisor = 0): DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return the original dividend, unmodified.
REQ-021 Signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0x00000000.
REQ-022 The special cases in REQ-020 and REQ-021 SHALL use the same fixed 33-cycle latency; there is no early termination.
REQ-023 START while BUSY=1 or in DONE_S SHALL be ignored and not queued.
REQ-024 START=1 in IDLE on the edge after DONE_S SHALL be accepted normally (back-to-back issue).
REQ-025 Changes to DATA1, DATA2 or FUNCT after the capture edge SHALL NOT affect the result.
REQ-026 RESULT SHALL hold its value between DONE pulses, changing only at FIX or reset.
REQ-027 Magnitude arithmetic SHALL treat 0x80000000 as unsigned 2^31; no 32-bit overflow may be lost in the negate or subtract paths.

Reset
REQ-028 When RESETN=0 at a rising edge, SHALL enter IDLE and set RESULT=0x00000000, BUSY=0, DONE=0, and clear the counter and accumulators.
REQ-029 Reset in any state, including mid-ITER, SHALL abort the operation; no DONE pulse follows for the aborted operation.
REQ-030 START sampled while RESETN=0 SHALL be ignored.

Verification
REQ-031 DIV 20 / -3 (0x00000014, 0xFFFFFFFD) -> RESULT 0xFFFFFFFA, DONE high exactly 33 cycles after the START edge, BUSY high for 33 cycles.
REQ-032 REM -20 % 3 -> 0xFFFFFFFE; REMU 0xFFFFFFFF % 2 -> 0x00000001; DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF.
REQ-033 Divide by zero: DIV 7/0 -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REM 7%0 -> 0x00000007; REM -7%0 -> 0xFFFFFFF9; all with 33-cycle latency.
REQ-034 Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0x00000000; DIVU of the same operands -> 0x00000000.
REQ-035 START pulsed again at cycle 5 of an operation and DATA1 changed at cycle 2 -> single DONE at cycle 33 with the original result; a back-to-back START the cycle after DONE -> second DONE 33 cycles later.
REQ-036 RESETN=0 at cycle 10 of an operation -> next cycle BUSY=0, RESULT=0x00000000, and no DONE within 40 cycles; a new START then completes correctly.
